// File: rtl/house_score_digits.sv
// house_score_digits
// Converts four house point totals to 6-digit BCD with a sequential
// double-dabble engine. The engine works one house at a time into a shadow
// bank, and the finished frame is copied atomically into the display bank.
// A separate registered lookup port answers per-digit requests from the
// leaderboard renderer. It always reads the display bank, so a frame is never
// torn while a conversion runs.
module house_score_digits #(
   parameter int HP_W      = 25,
   parameter int BIN_W     = 20,
   parameter int CLAMP_MAX = 999999
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [HP_W-1:0] G_HP,
   input  logic [HP_W-1:0] S_HP,
   input  logic [HP_W-1:0] R_HP,
   input  logic [HP_W-1:0] H_HP,
   input  logic            start,
   input  logic            G,
   input  logic            S,
   input  logic            R,
   input  logic            H,
   input  logic [2:0]      score,
   output logic            busy,
   output logic            done,
   output logic [3:0]      digit,
   output logic            blank,
   output logic            digit_vld
);

   localparam int BCD_W = 24;
   localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIN_W - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_SHIFT  = 3'd2,
      ST_STORE  = 3'd3,
      ST_COMMIT = 3'd4
   } state_t;

   state_t             state_r;
   state_t             next_s;
   logic [HP_W-1:0]    hp_lat_r [4];
   logic [1:0]         house_r;
   logic [CNT_W-1:0]   bit_cnt_r;
   logic [BIN_W-1:0]   bin_r;
   logic [BCD_W-1:0]   bcd_r;
   logic [BCD_W-1:0]   bcd_adj_s;
   logic [BCD_W-1:0]   shadow_r [4];
   logic [BCD_W-1:0]   disp_r [4];
   logic               busy_r;
   logic               done_r;
   logic [3:0]         digit_r;
   logic               blank_r;
   logic               digit_vld_r;

   logic [1:0]         lk_house_s;
   logic               house_ok_s;
   logic               score_ok_s;
   logic [2:0]         pos_s;
   logic [BCD_W-1:0]   word_s;
   logic [3:0]         lk_digit_s;
   logic               upper_nz_s;
   logic               lk_valid_s;
   logic               lk_blank_s;

   // Saturate a raw point total to the displayable maximum.
   function automatic logic [BIN_W-1:0] clamp_hp(input logic [HP_W-1:0] hp);
      logic [BIN_W-1:0] res;
      if (hp > HP_W'(CLAMP_MAX)) begin
         res = BIN_W'(CLAMP_MAX);
      end else begin
         res = hp[BIN_W-1:0];
      end
      return res;
   endfunction

   // Add 3 to every BCD nibble that is 5 or more (double-dabble correction).
   function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
      logic [BCD_W-1:0] res;
      logic [3:0]       nib;
      res = {BCD_W{1'b0}};
      for (int i = 0; i < 6; i++) begin
         nib = bcd[i*4 +: 4];
         res[i*4 +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
      end
      return res;
   endfunction

   assign bcd_adj_s = bcd_adjust(bcd_r);

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // FSM next-state logic: load, shift BIN_W times, store, per house, then commit.
   always_comb begin
      next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               next_s = ST_LOAD;
            end else begin
               next_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            next_s = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (bit_cnt_r == BIT_LAST) begin
               next_s = ST_STORE;
            end else begin
               next_s = ST_SHIFT;
            end
         end
         ST_STORE: begin
            if (house_r == 2'd3) begin
               next_s = ST_COMMIT;
            end else begin
               next_s = ST_LOAD;
            end
         end
         ST_COMMIT: begin
            next_s = ST_IDLE;
         end
         default: begin
            next_s = ST_IDLE;
         end
      endcase
   end

   // Conversion datapath, shadow/display banks and busy/done flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int h = 0; h < 4; h++) begin
            hp_lat_r[h] <= {HP_W{1'b0}};
            shadow_r[h] <= {BCD_W{1'b0}};
            disp_r[h]   <= {BCD_W{1'b0}};
         end
         house_r   <= 2'd0;
         bit_cnt_r <= {CNT_W{1'b0}};
         bin_r     <= {BIN_W{1'b0}};
         bcd_r     <= {BCD_W{1'b0}};
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  hp_lat_r[0] <= G_HP;
                  hp_lat_r[1] <= S_HP;
                  hp_lat_r[2] <= R_HP;
                  hp_lat_r[3] <= H_HP;
                  house_r     <= 2'd0;
                  busy_r      <= 1'b1;
               end
            end
            ST_LOAD: begin
               bin_r     <= clamp_hp(hp_lat_r[house_r]);
               bcd_r     <= {BCD_W{1'b0}};
               bit_cnt_r <= {CNT_W{1'b0}};
            end
            ST_SHIFT: begin
               bcd_r     <= {bcd_adj_s[BCD_W-2:0], bin_r[BIN_W-1]};
               bin_r     <= {bin_r[BIN_W-2:0], 1'b0};
               bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end
            ST_STORE: begin
               shadow_r[house_r] <= bcd_r;
               house_r           <= house_r + 2'd1;
            end
            ST_COMMIT: begin
               for (int h = 0; h < 4; h++) begin
                  disp_r[h] <= shadow_r[h];
               end
               done_r <= 1'b1;
               busy_r <= 1'b0;
            end
            default: begin
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   // Decode the renderer request and pick the digit and leading-zero flag.
   always_comb begin
      lk_house_s = 2'd0;
      house_ok_s = 1'b0;
      case ({G, S, R, H})
         4'b1000: begin lk_house_s = 2'd0; house_ok_s = 1'b1; end
         4'b0100: begin lk_house_s = 2'd1; house_ok_s = 1'b1; end
         4'b0010: begin lk_house_s = 2'd2; house_ok_s = 1'b1; end
         4'b0001: begin lk_house_s = 2'd3; house_ok_s = 1'b1; end
         default: begin lk_house_s = 2'd0; house_ok_s = 1'b0; end
      endcase
      score_ok_s = (score >= 3'd1) && (score <= 3'd6);
      pos_s      = score_ok_s ? (score - 3'd1) : 3'd0;
      word_s     = disp_r[lk_house_s];
      lk_digit_s = 4'd0;
      upper_nz_s = 1'b0;
      for (int i = 0; i < 6; i++) begin
         lk_digit_s = (3'(i) == pos_s) ? word_s[i*4 +: 4] : lk_digit_s;
         upper_nz_s = upper_nz_s | ((3'(i) >= pos_s) && (word_s[i*4 +: 4] != 4'd0));
      end
      lk_valid_s = house_ok_s & score_ok_s;
      lk_blank_s = lk_valid_s & (pos_s != 3'd0) & ~upper_nz_s;
   end

   // Register the lookup answer; invalid requests return all zeros.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         digit_r     <= 4'd0;
         blank_r     <= 1'b0;
         digit_vld_r <= 1'b0;
      end else begin
         digit_r     <= lk_valid_s ? lk_digit_s : 4'd0;
         blank_r     <= lk_blank_s;
         digit_vld_r <= lk_valid_s;
      end
   end

   assign busy      = busy_r;
   assign done      = done_r;
   assign digit     = digit_r;
   assign blank     = blank_r;
   assign digit_vld = digit_vld_r;

endmodule
